gmii_tx_frame_guard: RTL and testbench

TX-side counterpart to the RX packet-invalidation logic. Sits between the TX MAC framer and the GMII transmit pins. Forwards a byte stream onto GMII and enforces the minimum inter-packet gap. On upstream abort, underrun or oversize frames it poisons the frame on the wire with TX_ER, drains the rest of that frame from upstream, and reports a one-cycle error pulse.

---
 rtl/gmii_tx_guard_pkg.sv | 14 +
 rtl/ipg_timer.sv | 27 ++
 rtl/gmii_tx_frame_guard.sv | 141 ++++++++++++++
 tb/tb_gmii_tx_frame_guard.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gmii_tx_guard_pkg.sv
// Shared state encoding and GMII constants for the TX frame guard and related
// GMII framing blocks.
package gmii_tx_guard_pkg;

    typedef logic [1:0] tx_guard_state_t;

    localparam tx_guard_state_t IDLE  = 2'd0;
    localparam tx_guard_state_t FRAME = 2'd1;
    localparam tx_guard_state_t DRAIN = 2'd2;
    localparam tx_guard_state_t IPG   = 2'd3;

    localparam logic [7:0] GMII_IDLE_BYTE = 8'h00;

endpackage

// File: rtl/ipg_timer.sv
// Loadable down-counter that stops at zero; done is high whenever it rests at 0.
// Used for TX inter-packet gap timing and reusable for RX IFG checking.
module ipg_timer #(
    parameter int TIMER_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    output logic               done
);

    logic [TIMER_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - TIMER_W'(1);
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/gmii_tx_frame_guard.sv
// Forwards a framed byte stream onto GMII TX, enforces the minimum inter-packet
// gap and poisons aborted, underrun or oversize frames with a TX_ER cycle.
module gmii_tx_frame_guard
    import gmii_tx_guard_pkg::*;
#(
    parameter int MAX_FRAME_BYTES = 1530,
    parameter int IPG_BYTES       = 12,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       s_data,
    input  logic             s_valid,
    input  logic             s_last,
    input  logic             s_abort,
    output logic             s_ready,
    output logic [7:0]       gmii_txd,
    output logic             gmii_tx_en,
    output logic             gmii_tx_er,
    output logic             abort_pulse,
    output logic [CNT_W-1:0] abort_count
);

    localparam int BCNT_W = $clog2(MAX_FRAME_BYTES + 1);
    localparam int IPG_W  = (IPG_BYTES > 1) ? $clog2(IPG_BYTES) : 1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    tx_guard_state_t   state;
    tx_guard_state_t   state_nxt;
    logic [BCNT_W-1:0] byte_cnt;
    logic [BCNT_W-1:0] byte_cnt_nxt;
    logic [7:0]        txd_nxt;
    logic              en_nxt;
    logic              er_nxt;
    logic              pulse_nxt;
    logic              frame_err;
    logic              ipg_load;
    logic              ipg_done;

    assign s_ready = (state != IPG);

    // Abort, oversize and underrun all poison the wire identically; they only
    // differ in whether the offending beat was consumed (s_valid) or not.
    assign frame_err = !s_valid || s_abort ||
                       (byte_cnt == BCNT_W'(MAX_FRAME_BYTES));

    always_comb begin
        state_nxt    = state;
        byte_cnt_nxt = byte_cnt;
        txd_nxt      = GMII_IDLE_BYTE;
        en_nxt       = 1'b0;
        er_nxt       = 1'b0;
        pulse_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (s_valid) begin
                    if (s_abort) begin
                        pulse_nxt = 1'b1;
                        state_nxt = s_last ? IDLE : DRAIN;
                    end else begin
                        txd_nxt      = s_data;
                        en_nxt       = 1'b1;
                        byte_cnt_nxt = BCNT_W'(1);
                        state_nxt    = s_last ? IPG : FRAME;
                    end
                end
            end
            FRAME: begin
                if (frame_err) begin
                    en_nxt    = 1'b1;
                    er_nxt    = 1'b1;
                    pulse_nxt = 1'b1;
                    state_nxt = (s_valid && s_last) ? IPG : DRAIN;
                end else begin
                    txd_nxt      = s_data;
                    en_nxt       = 1'b1;
                    byte_cnt_nxt = byte_cnt + BCNT_W'(1);
                    if (s_last) begin
                        state_nxt = IPG;
                    end
                end
            end
            DRAIN: begin
                if (s_valid && s_last) begin
                    state_nxt = IPG;
                end
            end
            IPG: begin
                if (ipg_done) begin
                    state_nxt    = IDLE;
                    byte_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt    = IDLE;
                byte_cnt_nxt = '0;
            end
        endcase
    end

    // Loading on entry makes the IPG state last exactly IPG_BYTES cycles,
    // which lines up with the idle cycles seen on the registered pins.
    assign ipg_load = (state_nxt == IPG) && (state != IPG);

    ipg_timer #(
        .TIMER_W (IPG_W)
    ) u_ipg_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (ipg_load),
        .load_val (IPG_W'(IPG_BYTES - 1)),
        .done     (ipg_done)
    );

    // Output register stage: everything on the pins is one cycle after accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            byte_cnt    <= '0;
            gmii_txd    <= GMII_IDLE_BYTE;
            gmii_tx_en  <= 1'b0;
            gmii_tx_er  <= 1'b0;
            abort_pulse <= 1'b0;
            abort_count <= '0;
        end else begin
            state       <= state_nxt;
            byte_cnt    <= byte_cnt_nxt;
            gmii_txd    <= txd_nxt;
            gmii_tx_en  <= en_nxt;
            gmii_tx_er  <= er_nxt;
            abort_pulse <= pulse_nxt;
            if (pulse_nxt) begin
                abort_count <= sat_inc(abort_count);
            end
        end
    end

endmodule

// File: tb/tb_gmii_tx_frame_guard.sv
// Scoreboard bench for gmii_tx_frame_guard: expected wire bytes are queued as
// frames are driven and popped as the DUT puts them on GMII.
module tb_gmii_tx_frame_guard;

    localparam int MAX   = 64;
    localparam int IPG   = 12;
    localparam int CNT_W = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic       er;
        logic [7:0] d;
    } exp_t;

    logic             clk;
    logic             rst;
    logic [7:0]       s_data;
    logic             s_valid;
    logic             s_last;
    logic             s_abort;
    logic             s_ready;
    logic [7:0]       gmii_txd;
    logic             gmii_tx_en;
    logic             gmii_tx_er;
    logic             abort_pulse;
    logic [CNT_W-1:0] abort_count;

    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];
    int   pulses_exp = 0;
    int   pulses_seen = 0;
    int   pulses_base = 0;
    int   idle_run = 0;
    int   last_gap = 0;
    int   rdy_low_run = 0;
    int   last_rdy_low = 0;
    bit   mon_on = 0;

    gmii_tx_frame_guard #(
        .MAX_FRAME_BYTES (MAX),
        .IPG_BYTES       (IPG),
        .CNT_W           (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_last      (s_last),
        .s_abort     (s_abort),
        .s_ready     (s_ready),
        .gmii_txd    (gmii_txd),
        .gmii_tx_en  (gmii_tx_en),
        .gmii_tx_er  (gmii_tx_er),
        .abort_pulse (abort_pulse),
        .abort_count (abort_count)
    );

    initial begin
        clk = 1'b0;
        forever #4 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic er, input logic [7:0] d);
        exp_t e;
        e.er = er;
        e.d  = d;
        return e;
    endfunction

    function automatic int exp_cnt();
        return (pulses_exp > CNT_MAX) ? CNT_MAX : pulses_exp;
    endfunction

    // Monitor: pops expected bytes and tracks gap / ready-low run lengths.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_on) begin
                if (gmii_tx_en) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_en", {gmii_tx_er, gmii_txd}, 32'h1ff);
                    end else begin
                        e = exp_q.pop_front();
                        chk("txd", gmii_txd, e.d);
                        chk("tx_er", gmii_tx_er, e.er);
                    end
                    if (gmii_tx_er) chk("er_pulse", abort_pulse, 1);
                    if (idle_run > 0) last_gap = idle_run;
                    idle_run = 0;
                end else begin
                    chk("idle_pins", {gmii_tx_er, gmii_txd}, 0);
                    idle_run++;
                end
                if (abort_pulse) pulses_seen++;
                if (!s_ready) begin
                    rdy_low_run++;
                end else if (rdy_low_run > 0) begin
                    last_rdy_low = rdy_low_run;
                    rdy_low_run  = 0;
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic put_beat(input logic [7:0] d, input logic last, input logic ab);
        logic rdy;
        int   waited;
        waited  = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        s_abort = ab;
        forever begin
            rdy = s_ready;
            @(negedge clk);
            if (rdy) break;
            waited++;
            if (waited > 100) begin
                chk("ready_wait", rdy, 1);
                break;
            end
        end
        s_valid = 1'b0;
        s_data  = 8'($urandom);
        s_last  = 1'($urandom);
        s_abort = 1'($urandom);
    endtask

    task automatic send_frame(input int len, input int abort_at, input int gap_at,
                              input logic [7:0] seed);
        bit         bad;
        logic [7:0] d;
        bad = 0;
        for (int i = 1; i <= len; i++) begin
            if (i == gap_at && !bad) begin
                exp_q.push_back(mk(1'b1, 8'h00));
                pulses_exp++;
                bad = 1;
                @(negedge clk);
            end
            d = seed + 8'(i);
            if (!bad) begin
                if (i == abort_at) begin
                    if (i > 1) exp_q.push_back(mk(1'b1, 8'h00));
                    pulses_exp++;
                    bad = 1;
                end else if (i > MAX) begin
                    exp_q.push_back(mk(1'b1, 8'h00));
                    pulses_exp++;
                    bad = 1;
                end else begin
                    exp_q.push_back(mk(1'b0, d));
                end
            end
            put_beat(d, (i == len), (i == abort_at));
        end
    endtask

    task automatic end_checks(input string tag, input bit ipg_expected);
        idle(16);
        if (ipg_expected) chk({tag, "_ipg_ready_low"}, last_rdy_low, IPG);
        chk({tag, "_sb_empty"}, exp_q.size(), 0);
        chk({tag, "_pulses"}, pulses_seen - pulses_base, pulses_exp);
        chk({tag, "_abort_count"}, abort_count, exp_cnt());
    endtask

    initial begin
        logic [7:0] d;
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = 8'h00;
        s_last  = 1'b0;
        s_abort = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_txd", gmii_txd, 0);
        chk("rst_en", gmii_tx_en, 0);
        chk("rst_er", gmii_tx_er, 0);
        chk("rst_pulse", abort_pulse, 0);
        chk("rst_count", abort_count, 0);
        chk("rst_ready", s_ready, 1);
        rst    = 1'b0;
        mon_on = 1;
        idle(2);

        // Back-to-back frames: the first is exactly MAX bytes long.
        send_frame(64, 0, 0, 8'h10);
        send_frame(20, 0, 0, 8'h80);
        end_checks("t1", 1);
        chk("t1_gap", last_gap, IPG);

        // Underrun after byte 40 of a 100-byte frame.
        send_frame(100, 0, 41, 8'h20);
        end_checks("t2", 1);

        // Mid-frame abort, then abort together with s_last.
        send_frame(50, 10, 0, 8'h30);
        send_frame(10, 10, 0, 8'h40);
        end_checks("t3", 1);

        // Oversize: beat MAX+1 is poisoned, remainder drained; counter saturates.
        send_frame(69, 0, 0, 8'h50);
        end_checks("t4", 1);

        // Abort on the first beat: nothing on the wire, drain, then IPG.
        send_frame(30, 1, 0, 8'h60);
        end_checks("t5", 1);

        // Single-beat abort with s_last returns straight to IDLE.
        send_frame(1, 1, 0, 8'h70);
        chk("t6_ready_after_idle_abort", s_ready, 1);
        end_checks("t6", 0);

        // Single-byte good frame.
        send_frame(1, 0, 0, 8'h77);
        end_checks("t6b", 1);

        // Reset in the middle of a frame.
        for (int i = 1; i <= 14; i++) begin
            d = 8'h90 + 8'(i);
            exp_q.push_back(mk(1'b0, d));
            put_beat(d, 1'b0, 1'b0);
        end
        s_valid = 1'b1;
        s_data  = 8'h9f;
        s_last  = 1'b0;
        s_abort = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        chk("t7_rst_en", gmii_tx_en, 0);
        chk("t7_rst_er", gmii_tx_er, 0);
        chk("t7_rst_txd", gmii_txd, 0);
        chk("t7_rst_pulse", abort_pulse, 0);
        chk("t7_rst_count", abort_count, 0);
        chk("t7_rst_ready", s_ready, 1);
        rst         = 1'b0;
        s_valid     = 1'b0;
        pulses_exp  = 0;
        pulses_base = pulses_seen;
        idle(2);
        send_frame(20, 0, 0, 8'hA0);
        end_checks("t7", 1);

        chk("final_sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
